// File: rtl/io_bus_pkg.sv
// Shared constants for the mouse FIFO peripheral: bus width, register offsets
// and the bit positions inside FIFO_CMD, FLAGS and CTRL.
package io_bus_pkg;

    localparam int BUS_W = 8;

    localparam logic [2:0] OFF_HEAD_STATUS = 3'd0;
    localparam logic [2:0] OFF_HEAD_X      = 3'd1;
    localparam logic [2:0] OFF_HEAD_Y      = 3'd2;
    localparam logic [2:0] OFF_FIFO_CMD    = 3'd3;
    localparam logic [2:0] OFF_IRQ_THRESH  = 3'd4;
    localparam logic [2:0] OFF_FLAGS       = 3'd5;
    localparam logic [2:0] OFF_CTRL        = 3'd6;
    localparam logic [2:0] OFF_DROP_CNT    = 3'd7;

    localparam int CMD_POP_BIT        = 0;
    localparam int CMD_FLUSH_BIT      = 1;
    localparam int FLAGS_EMPTY_BIT    = 0;
    localparam int FLAGS_FULL_BIT     = 1;
    localparam int FLAGS_OVF_BIT      = 2;
    localparam int CTRL_IRQ_EN_BIT    = 0;
    localparam int CTRL_OVERWRITE_BIT = 1;

endpackage

// File: rtl/packet_fifo.sv
// Circular packet buffer with drop/overwrite overflow policy and flush.
// Push is a valid-only handshake: a push is always consumed on the cycle it is
// high (there is no ready); when full, the overwrite input and a same-cycle
// pop decide whether the packet is stored, and overflow pulses if it is lost
// or replaces the oldest entry.
module packet_fifo
    import io_bus_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic                     overwrite,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_write;
    logic             adv_rd;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign head  = empty ? '0 : mem[rd_ptr];

    // Decide which pointers move this cycle; flush overrides everything.
    always_comb begin
        do_pop   = pop && !empty && !flush;
        do_write = push && !flush && (!full || do_pop || overwrite);
        adv_rd   = do_pop || (push && !flush && full && overwrite);
        overflow = push && !flush && full && !do_pop;
    end

    // Pointer and occupancy update; reset and flush both empty the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
            if (adv_rd)   rd_ptr <= rd_ptr + PTR_ONE;
            if (do_write && !adv_rd)      count <= count + CNT_ONE;
            else if (adv_rd && !do_write) count <= count - CNT_ONE;
        end
    end

    // Packet storage; contents are meaningless while count says empty.
    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/io_bus_mouse_fifo.sv
// Bus-mapped mouse peripheral: queues transceiver packets in packet_fifo and
// exposes head packet, FIFO control, threshold interrupt and drop statistics
// through an 8-byte register window with a registered tristate read path.
module io_bus_mouse_fifo
    import io_bus_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR  = 8'hA0,
    parameter int         FIFO_DEPTH = 8,
    parameter int         STATUS_W   = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    inout  wire  [BUS_W-1:0]    BUS_DATA,
    input  logic [7:0]          BUS_ADDR,
    input  logic                BUS_WE,
    input  logic                PKT_VALID,
    input  logic [STATUS_W-1:0] PKT_STATUS,
    input  logic [7:0]          PKT_X,
    input  logic [7:0]          PKT_Y,
    output logic                BUS_INTERRUPT_RAISE,
    input  logic                BUS_INTERRUPT_ACK
);

    localparam int         WIDTH  = STATUS_W + 16;
    localparam int         CW     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0] DEPTH8 = FIFO_DEPTH[7:0];

    logic             cs, wr_en, rd_en;
    logic [2:0]       offset;
    logic [7:0]       wdata;
    logic             fifo_pop, fifo_flush, fifo_full, fifo_empty, fifo_ovf;
    logic [WIDTH-1:0] fifo_head;
    logic [CW-1:0]    fifo_count;
    logic [7:0]       irq_thresh, thresh_wr, drop_cnt, cnt_ext, cnt_after, rd_mux, rd_q;
    logic             ovf, irq_en, overwrite, irq_en_next, irq_set, drive_q;

    assign cs         = (BUS_ADDR[7:3] == BASE_ADDR[7:3]);
    assign offset     = BUS_ADDR[2:0];
    assign wr_en      = cs && BUS_WE;
    assign rd_en      = cs && !BUS_WE;
    assign wdata      = BUS_DATA;
    assign fifo_pop   = wr_en && (offset == OFF_FIFO_CMD) && wdata[CMD_POP_BIT];
    assign fifo_flush = wr_en && (offset == OFF_FIFO_CMD) && wdata[CMD_FLUSH_BIT];

    packet_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (CLK),
        .rst_n    (RESET),
        .push     (PKT_VALID),
        .pop      (fifo_pop),
        .flush    (fifo_flush),
        .overwrite(overwrite),
        .din      ({PKT_STATUS, PKT_X, PKT_Y}),
        .head     (fifo_head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (fifo_ovf)
    );

    // Threshold write sanitising, post-push occupancy and interrupt decision.
    always_comb begin
        if (wdata == 8'd0)        thresh_wr = 8'd1;
        else if (wdata > DEPTH8)  thresh_wr = DEPTH8;
        else                      thresh_wr = wdata;
        cnt_ext = '0;
        cnt_ext[CW-1:0] = fifo_count;
        // A push into a full FIFO, or paired with a real pop, leaves count unchanged.
        cnt_after = cnt_ext + {7'd0, !(fifo_full || (fifo_pop && !fifo_empty))};
        irq_set = PKT_VALID && !fifo_flush && irq_en && (cnt_after >= irq_thresh);
        irq_en_next = (wr_en && offset == OFF_CTRL) ? wdata[CTRL_IRQ_EN_BIT] : irq_en;
    end

    // Read mux: head fields read zero when empty because the FIFO blanks its head.
    always_comb begin
        rd_mux = '0;
        case (offset)
            OFF_HEAD_STATUS: rd_mux[STATUS_W-1:0] = fifo_head[WIDTH-1:16];
            OFF_HEAD_X:      rd_mux = fifo_head[15:8];
            OFF_HEAD_Y:      rd_mux = fifo_head[7:0];
            OFF_FIFO_CMD:    rd_mux[CW-1:0] = fifo_count;
            OFF_IRQ_THRESH:  rd_mux = irq_thresh;
            OFF_FLAGS: begin
                rd_mux[FLAGS_OVF_BIT]   = ovf;
                rd_mux[FLAGS_FULL_BIT]  = fifo_full;
                rd_mux[FLAGS_EMPTY_BIT] = fifo_empty;
            end
            OFF_CTRL: begin
                rd_mux[CTRL_IRQ_EN_BIT]    = irq_en;
                rd_mux[CTRL_OVERWRITE_BIT] = overwrite;
            end
            default:         rd_mux = drop_cnt;
        endcase
    end

    // Programmable registers; a loss event wins over a same-cycle clear.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            irq_thresh <= 8'd1;
            irq_en     <= 1'b0;
            overwrite  <= 1'b0;
            ovf        <= 1'b0;
            drop_cnt   <= 8'd0;
        end else begin
            if (wr_en && offset == OFF_IRQ_THRESH) irq_thresh <= thresh_wr;
            if (wr_en && offset == OFF_CTRL) begin
                irq_en    <= wdata[CTRL_IRQ_EN_BIT];
                overwrite <= wdata[CTRL_OVERWRITE_BIT];
            end
            if (fifo_ovf)
                ovf <= 1'b1;
            else if (wr_en && offset == OFF_FLAGS && wdata[FLAGS_OVF_BIT])
                ovf <= 1'b0;
            if (fifo_ovf) begin
                if (wr_en && offset == OFF_DROP_CNT) drop_cnt <= 8'd1;
                else if (drop_cnt != 8'hFF)          drop_cnt <= drop_cnt + 8'd1;
            end else if (wr_en && offset == OFF_DROP_CNT) begin
                drop_cnt <= 8'd0;
            end
        end
    end

    // Interrupt flag: disable clears, otherwise set beats acknowledge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)                 BUS_INTERRUPT_RAISE <= 1'b0;
        else if (!irq_en_next)      BUS_INTERRUPT_RAISE <= 1'b0;
        else if (irq_set)           BUS_INTERRUPT_RAISE <= 1'b1;
        else if (BUS_INTERRUPT_ACK) BUS_INTERRUPT_RAISE <= 1'b0;
    end

    // Registered read data and drive enable: bus is driven the cycle after a read.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_q    <= 8'd0;
            drive_q <= 1'b0;
        end else begin
            drive_q <= rd_en;
            if (rd_en) rd_q <= rd_mux;
        end
    end

    assign BUS_DATA = drive_q ? rd_q : 8'bz;

endmodule

// File: tb/tb_io_bus_mouse_fifo.sv
// Directed bench for io_bus_mouse_fifo: reset values, head/pop, drop and
// overwrite overflow, interrupt threshold/ack, full push+pop, flush+push and
// asynchronous reset. BUS_DATA is pulled high so an undriven bus reads 0xFF.
module tb_io_bus_mouse_fifo;

    logic       CLK;
    logic       RESET;
    wire  [7:0] BUS_DATA;
    logic [7:0] BUS_ADDR;
    logic       BUS_WE;
    logic       PKT_VALID;
    logic [3:0] PKT_STATUS;
    logic [7:0] PKT_X;
    logic [7:0] PKT_Y;
    logic       BUS_INTERRUPT_RAISE;
    logic       BUS_INTERRUPT_ACK;
    logic       tb_oe;
    logic [7:0] tb_wdata;

    int n_cmp  = 0;
    int n_fail = 0;

    assign BUS_DATA = tb_oe ? tb_wdata : 8'bz;

    for (genvar i = 0; i < 8; i++) begin : g_pull
        pullup (BUS_DATA[i]);
    end

    io_bus_mouse_fifo #(.BASE_ADDR(8'hA0), .FIFO_DEPTH(8), .STATUS_W(4)) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .BUS_DATA           (BUS_DATA),
        .BUS_ADDR           (BUS_ADDR),
        .BUS_WE             (BUS_WE),
        .PKT_VALID          (PKT_VALID),
        .PKT_STATUS         (PKT_STATUS),
        .PKT_X              (PKT_X),
        .PKT_Y              (PKT_Y),
        .BUS_INTERRUPT_RAISE(BUS_INTERRUPT_RAISE),
        .BUS_INTERRUPT_ACK  (BUS_INTERRUPT_ACK)
    );

    // Clock and watchdog
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic read_reg(input logic [2:0] off, output logic [7:0] data, output logic [7:0] after);
        @(negedge CLK);
        BUS_ADDR = 8'hA0 + {5'd0, off};
        BUS_WE   = 1'b0;
        @(negedge CLK);
        data     = BUS_DATA;
        BUS_ADDR = 8'h00;
        @(negedge CLK);
        after    = BUS_DATA;
    endtask

    task automatic write_reg(input logic [2:0] off, input logic [7:0] val);
        @(negedge CLK);
        BUS_ADDR = 8'hA0 + {5'd0, off};
        BUS_WE   = 1'b1;
        tb_oe    = 1'b1;
        tb_wdata = val;
        @(negedge CLK);
        BUS_WE   = 1'b0;
        tb_oe    = 1'b0;
        BUS_ADDR = 8'h00;
    endtask

    // Push one packet, optionally with a same-cycle FIFO_CMD write and/or ACK.
    task automatic push_pkt(input logic [3:0] st, input logic [7:0] x, input logic [7:0] y,
                            input logic with_cmd, input logic [7:0] cmd, input logic ack);
        @(negedge CLK);
        PKT_VALID  = 1'b1;
        PKT_STATUS = st;
        PKT_X      = x;
        PKT_Y      = y;
        BUS_INTERRUPT_ACK = ack;
        if (with_cmd) begin
            BUS_ADDR = 8'hA3;
            BUS_WE   = 1'b1;
            tb_oe    = 1'b1;
            tb_wdata = cmd;
        end
        @(negedge CLK);
        PKT_VALID = 1'b0;
        BUS_INTERRUPT_ACK = 1'b0;
        BUS_WE   = 1'b0;
        tb_oe    = 1'b0;
        BUS_ADDR = 8'h00;
    endtask

    task automatic clean_fifo();
        write_reg(3'd3, 8'h02);
        write_reg(3'd5, 8'h04);
        write_reg(3'd7, 8'h00);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [7:0] d, z;
        logic [7:0] exp_v [8];
        exp_v = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00};
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (BUS_INTERRUPT_RAISE !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_raise: got %b want 0", BUS_INTERRUPT_RAISE);
        end
        n_cmp++;
        if (BUS_DATA !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_bus_hiz: got %h want undriven (ff)", BUS_DATA);
        end
        RESET = 1'b1;
        for (int i = 0; i < 8; i++) begin
            read_reg(i[2:0], d, z);
            n_cmp++;
            if (d !== exp_v[i]) begin
                n_fail++;
                $display("FAIL reset_reg%0d: got %h want %h", i, d, exp_v[i]);
            end
            n_cmp++;
            if (z !== 8'hFF) begin
                n_fail++;
                $display("FAIL reset_hiz%0d: got %h want undriven (ff)", i, z);
            end
        end
    endtask

    task automatic test_push_pop();
        logic [7:0] d, z;
        logic [7:0] exp_a [3];
        logic [7:0] exp_b [3];
        exp_a = '{8'h03, 8'h10, 8'h20};
        exp_b = '{8'h05, 8'h11, 8'h21};
        push_pkt(4'd3, 8'h10, 8'h20, 1'b0, 8'h00, 1'b0);
        push_pkt(4'd5, 8'h11, 8'h21, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            read_reg(i[2:0], d, z);
            n_cmp++;
            if (d !== exp_a[i]) begin
                n_fail++;
                $display("FAIL head_first_off%0d: got %h want %h", i, d, exp_a[i]);
            end
        end
        write_reg(3'd3, 8'h01);
        for (int i = 0; i < 3; i++) begin
            read_reg(i[2:0], d, z);
            n_cmp++;
            if (d !== exp_b[i]) begin
                n_fail++;
                $display("FAIL head_after_pop_off%0d: got %h want %h", i, d, exp_b[i]);
            end
        end
        read_reg(3'd3, d, z);
        n_cmp++;
        if (d !== 8'h01) begin
            n_fail++;
            $display("FAIL count_after_pop: got %h want 01", d);
        end
        // Drain, then pop on empty: count stays 0 and the head reads zero.
        write_reg(3'd3, 8'h01);
        write_reg(3'd3, 8'h01);
        read_reg(3'd3, d, z);
        n_cmp++;
        if (d !== 8'h00) begin
            n_fail++;
            $display("FAIL pop_empty_count: got %h want 00", d);
        end
        read_reg(3'd1, d, z);
        n_cmp++;
        if (d !== 8'h00) begin
            n_fail++;
            $display("FAIL empty_head_x: got %h want 00", d);
        end
    endtask

    // Ten pushes into an 8-deep FIFO; head_idx is the packet expected at the head.
    task automatic test_overflow(input logic [7:0] ctrl, input int head_idx);
        logic [7:0] d, z;
        write_reg(3'd6, ctrl);
        for (int i = 1; i <= 10; i++)
            push_pkt(i[3:0], 8'h30 + 8'(i), 8'h40 + 8'(i), 1'b0, 8'h00, 1'b0);
        read_reg(3'd3, d, z);
        n_cmp++;
        if (d !== 8'h08) begin
            n_fail++;
            $display("FAIL ovf_count ctrl=%h: got %h want 08", ctrl, d);
        end
        read_reg(3'd5, d, z);
        n_cmp++;
        if (d !== 8'h06) begin
            n_fail++;
            $display("FAIL ovf_flags ctrl=%h: got %h want 06", ctrl, d);
        end
        read_reg(3'd7, d, z);
        n_cmp++;
        if (d !== 8'h02) begin
            n_fail++;
            $display("FAIL ovf_drop_cnt ctrl=%h: got %h want 02", ctrl, d);
        end
        read_reg(3'd0, d, z);
        n_cmp++;
        if (d !== 8'(head_idx)) begin
            n_fail++;
            $display("FAIL ovf_head_status ctrl=%h: got %h want %h", ctrl, d, 8'(head_idx));
        end
        read_reg(3'd1, d, z);
        n_cmp++;
        if (d !== 8'h30 + 8'(head_idx)) begin
            n_fail++;
            $display("FAIL ovf_head_x ctrl=%h: got %h want %h", ctrl, d, 8'h30 + 8'(head_idx));
        end
        read_reg(3'd2, d, z);
        n_cmp++;
        if (d !== 8'h40 + 8'(head_idx)) begin
            n_fail++;
            $display("FAIL ovf_head_y ctrl=%h: got %h want %h", ctrl, d, 8'h40 + 8'(head_idx));
        end
        clean_fifo();
        read_reg(3'd5, d, z);
        n_cmp++;
        if (d !== 8'h01) begin
            n_fail++;
            $display("FAIL ovf_cleared_flags ctrl=%h: got %h want 01", ctrl, d);
        end
        read_reg(3'd7, d, z);
        n_cmp++;
        if (d !== 8'h00) begin
            n_fail++;
            $display("FAIL drop_cnt_cleared ctrl=%h: got %h want 00", ctrl, d);
        end
    endtask

    task automatic test_irq();
        logic [7:0] d, z;
        write_reg(3'd4, 8'h00);
        read_reg(3'd4, d, z);
        n_cmp++;
        if (d !== 8'h01) begin
            n_fail++;
            $display("FAIL thresh_zero: got %h want 01", d);
        end
        write_reg(3'd4, 8'd20);
        read_reg(3'd4, d, z);
        n_cmp++;
        if (d !== 8'h08) begin
            n_fail++;
            $display("FAIL thresh_saturate: got %h want 08", d);
        end
        write_reg(3'd4, 8'h03);
        write_reg(3'd6, 8'h01);
        push_pkt(4'd1, 8'h01, 8'h01, 1'b0, 8'h00, 1'b0);
        push_pkt(4'd2, 8'h02, 8'h02, 1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (BUS_INTERRUPT_RAISE !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_below_thresh: got %b want 0", BUS_INTERRUPT_RAISE);
        end
        push_pkt(4'd3, 8'h03, 8'h03, 1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (BUS_INTERRUPT_RAISE !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_at_thresh: got %b want 1", BUS_INTERRUPT_RAISE);
        end
        push_pkt(4'd4, 8'h04, 8'h04, 1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (BUS_INTERRUPT_RAISE !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_set_beats_ack: got %b want 1", BUS_INTERRUPT_RAISE);
        end
        @(negedge CLK);
        BUS_INTERRUPT_ACK = 1'b1;
        @(negedge CLK);
        BUS_INTERRUPT_ACK = 1'b0;
        n_cmp++;
        if (BUS_INTERRUPT_RAISE !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_ack_clears: got %b want 0", BUS_INTERRUPT_RAISE);
        end
        push_pkt(4'd5, 8'h05, 8'h05, 1'b0, 8'h00, 1'b0);
        write_reg(3'd6, 8'h00);
        n_cmp++;
        if (BUS_INTERRUPT_RAISE !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_disable_clears: got %b want 0", BUS_INTERRUPT_RAISE);
        end
        clean_fifo();
    endtask

    task automatic test_back_to_back();
        logic [7:0] d, z;
        write_reg(3'd6, 8'h00);
        for (int i = 1; i <= 8; i++)
            push_pkt(i[3:0], 8'h50 + 8'(i), 8'h60 + 8'(i), 1'b0, 8'h00, 1'b0);
        push_pkt(4'hA, 8'h5A, 8'h6A, 1'b1, 8'h01, 1'b0);
        read_reg(3'd3, d, z);
        n_cmp++;
        if (d !== 8'h08) begin
            n_fail++;
            $display("FAIL full_push_pop_count: got %h want 08", d);
        end
        read_reg(3'd5, d, z);
        n_cmp++;
        if (d !== 8'h02) begin
            n_fail++;
            $display("FAIL full_push_pop_flags: got %h want 02", d);
        end
        read_reg(3'd1, d, z);
        n_cmp++;
        if (d !== 8'h52) begin
            n_fail++;
            $display("FAIL full_push_pop_head_x: got %h want 52", d);
        end
        push_pkt(4'hB, 8'h5B, 8'h6B, 1'b1, 8'h02, 1'b0);
        read_reg(3'd3, d, z);
        n_cmp++;
        if (d !== 8'h00) begin
            n_fail++;
            $display("FAIL flush_push_count: got %h want 00", d);
        end
        read_reg(3'd7, d, z);
        n_cmp++;
        if (d !== 8'h00) begin
            n_fail++;
            $display("FAIL flush_push_drop_cnt: got %h want 00", d);
        end
        read_reg(3'd5, d, z);
        n_cmp++;
        if (d !== 8'h01) begin
            n_fail++;
            $display("FAIL flush_push_flags: got %h want 01", d);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] d, z;
        write_reg(3'd4, 8'h03);
        write_reg(3'd6, 8'h01);
        for (int i = 1; i <= 4; i++)
            push_pkt(i[3:0], 8'h70 + 8'(i), 8'h80 + 8'(i), 1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (BUS_INTERRUPT_RAISE !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_raise: got %b want 1", BUS_INTERRUPT_RAISE);
        end
        @(negedge CLK);
        #2 RESET = 1'b0;
        #1;
        n_cmp++;
        if (BUS_INTERRUPT_RAISE !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_raise: got %b want 0", BUS_INTERRUPT_RAISE);
        end
        n_cmp++;
        if (dut.u_fifo.count !== 4'd0) begin
            n_fail++;
            $display("FAIL async_reset_count: got %h want 0", dut.u_fifo.count);
        end
        @(negedge CLK);
        RESET = 1'b1;
        read_reg(3'd3, d, z);
        n_cmp++;
        if (d !== 8'h00) begin
            n_fail++;
            $display("FAIL post_reset_count: got %h want 00", d);
        end
        read_reg(3'd4, d, z);
        n_cmp++;
        if (d !== 8'h01) begin
            n_fail++;
            $display("FAIL post_reset_thresh: got %h want 01", d);
        end
    endtask

    // Sequencer and final report
    initial begin
        RESET = 1'b0;
        BUS_ADDR = 8'h00;
        BUS_WE = 1'b0;
        PKT_VALID = 1'b0;
        PKT_STATUS = 4'd0;
        PKT_X = 8'h00;
        PKT_Y = 8'h00;
        BUS_INTERRUPT_ACK = 1'b0;
        tb_oe = 1'b0;
        tb_wdata = 8'h00;
        test_reset();
        test_push_pop();
        test_overflow(8'h00, 1);
        test_overflow(8'h02, 3);
        test_irq();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
